// File: rtl/id_ex_issue.sv
// Decode/issue stage: decodes IF/ID, resolves operands with EX, EX/MEM and MEM/WB
// forwarding, detects load-use hazards and owns the ID/EX register feeding the ALU.
// Latency: one clock from IF/ID to ID/EX. Backpressure: stall (combinational) holds PC
// and IF/ID while a bubble is issued.
// Ports: clk/rst; instr_valid/instr/flush from IF/ID; rs/rt register-file read port;
// EX, EX/MEM and MEM/WB forwarding sources; stall; registered ex_* ALU/memory controls.
module id_ex_issue #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    input  logic             flush,
    output logic [RSIZE-1:0] rs_addr,
    output logic [RSIZE-1:0] rt_addr,
    input  logic [DSIZE-1:0] rs_data,
    input  logic [DSIZE-1:0] rt_data,
    input  logic [DSIZE-1:0] ex_alu_result,
    input  logic             exmem_wen,
    input  logic             exmem_is_load,
    input  logic [RSIZE-1:0] exmem_rd,
    input  logic [DSIZE-1:0] exmem_data,
    input  logic             memwb_wen,
    input  logic [RSIZE-1:0] memwb_rd,
    input  logic [DSIZE-1:0] memwb_data,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_reg_wen,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [2:0]       ex_alu_op,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_store_data,
    output logic [RSIZE-1:0] ex_rd
);

    typedef enum logic {RUN, STALL} state_e;
    state_e state_q, state_d;

    logic [3:0]       opcode;
    logic [RSIZE-1:0] f_rd, f_rs, f_rt;
    logic [DSIZE-1:0] imm_sext;

    logic       dec_wen, dec_mread, dec_mwrite, use_rs, use_rt, b_imm;
    logic [2:0] dec_op;

    logic             ex_valid_q, ex_reg_wen_q, ex_mem_read_q, ex_mem_write_q;
    logic             ex_valid_d, ex_reg_wen_d, ex_mem_read_d, ex_mem_write_d;
    logic [2:0]       ex_alu_op_q, ex_alu_op_d;
    logic [DSIZE-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_store_data_q, ex_store_data_d;
    logic [RSIZE-1:0] ex_rd_q, ex_rd_d;

    logic [DSIZE-1:0] rs_val, rt_val;
    logic             haz_rs, haz_rt;

    assign opcode   = instr[15:12];
    assign f_rd     = instr[8 +: RSIZE];
    assign f_rs     = instr[4 +: RSIZE];
    assign f_rt     = instr[0 +: RSIZE];
    assign imm_sext = {{(DSIZE-4){instr[3]}}, instr[3:0]};

    // SW reads its store source through the rt port using the rd field.
    assign rs_addr = f_rs;
    assign rt_addr = (opcode == 4'd8) ? f_rd : f_rt;

    always_comb begin
        dec_op     = 3'b000;
        dec_wen    = 1'b0;
        dec_mread  = 1'b0;
        dec_mwrite = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        b_imm      = 1'b0;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                dec_op  = opcode[2:0];
                dec_wen = 1'b1;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            4'd6: begin
                dec_wen = 1'b1;
                use_rs  = 1'b1;
                b_imm   = 1'b1;
            end
            4'd7: begin
                dec_wen   = 1'b1;
                dec_mread = 1'b1;
                use_rs    = 1'b1;
                b_imm     = 1'b1;
            end
            4'd8: begin
                dec_mwrite = 1'b1;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
                b_imm      = 1'b1;
            end
            default: ;  // illegal opcodes issue as a NOP
        endcase
    end

    // Youngest producer wins; a load in EX or EX/MEM has no data yet, so it is
    // skipped here and caught by the hazard check instead.
    function automatic logic [DSIZE-1:0] fwd(input logic [RSIZE-1:0] r,
                                             input logic [DSIZE-1:0] rf_val);
        if (r == '0)
            return '0;
        else if (ex_valid_q && ex_reg_wen_q && ex_rd_q == r && !ex_mem_read_q)
            return ex_alu_result;
        else if (exmem_wen && exmem_rd == r && !exmem_is_load)
            return exmem_data;
        else if (memwb_wen && memwb_rd == r)
            return memwb_data;
        else
            return rf_val;
    endfunction

    function automatic logic load_pending(input logic [RSIZE-1:0] r);
        return (r != '0) &&
               ((ex_valid_q && ex_mem_read_q && ex_rd_q == r) ||
                (exmem_wen && exmem_is_load && exmem_rd == r));
    endfunction

    always_comb begin
        rs_val = fwd(rs_addr, rs_data);
        rt_val = fwd(rt_addr, rt_data);
        haz_rs = use_rs && load_pending(rs_addr);
        haz_rt = use_rt && load_pending(rt_addr);
        stall  = !rst && instr_valid && !flush && (haz_rs || haz_rt);
    end

    // Informational stall tracker; flush always returns it to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall) state_d = STALL;
            STALL:   if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush) state_d = RUN;
    end

    always_comb begin
        ex_valid_d      = 1'b0;
        ex_reg_wen_d    = 1'b0;
        ex_mem_read_d   = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_alu_op_d     = 3'b000;
        ex_a_d          = '0;
        ex_b_d          = '0;
        ex_store_data_d = '0;
        ex_rd_d         = '0;
        if (instr_valid && !flush && !stall) begin
            ex_valid_d      = 1'b1;
            ex_reg_wen_d    = dec_wen;
            ex_mem_read_d   = dec_mread;
            ex_mem_write_d  = dec_mwrite;
            ex_alu_op_d     = dec_op;
            ex_a_d          = use_rs ? rs_val : '0;
            ex_b_d          = b_imm ? imm_sext : (use_rt ? rt_val : '0);
            ex_store_data_d = dec_mwrite ? rt_val : '0;
            ex_rd_d         = dec_wen ? f_rd : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            ex_valid_q      <= 1'b0;
            ex_reg_wen_q    <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_alu_op_q     <= 3'b000;
            ex_a_q          <= '0;
            ex_b_q          <= '0;
            ex_store_data_q <= '0;
            ex_rd_q         <= '0;
        end else begin
            state_q         <= state_d;
            ex_valid_q      <= ex_valid_d;
            ex_reg_wen_q    <= ex_reg_wen_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_a_q          <= ex_a_d;
            ex_b_q          <= ex_b_d;
            ex_store_data_q <= ex_store_data_d;
            ex_rd_q         <= ex_rd_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_wen    = ex_reg_wen_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_alu_op     = ex_alu_op_q;
    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_rd         = ex_rd_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: directed scenarios plus randomized traffic against a
// table-driven reference model of decode, forwarding priority and load-use hazards.
// Inputs change 1 ns after the rising edge; outputs are sampled before/after the edge.
module tb_id_ex_issue;

    logic        clk, rst, instr_valid, flush;
    logic [15:0] instr;
    logic [3:0]  rs_addr, rt_addr;
    logic [15:0] rs_data, rt_data, ex_alu_result;
    logic        exmem_wen, exmem_is_load;
    logic [3:0]  exmem_rd;
    logic [15:0] exmem_data;
    logic        memwb_wen;
    logic [3:0]  memwb_rd;
    logic [15:0] memwb_data;
    logic        stall, ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_alu_op;
    logic [15:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_rd;

    logic [15:0] rf [16];
    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    id_ex_issue #(.DSIZE(16), .RSIZE(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .ex_alu_result(ex_alu_result), .exmem_wen(exmem_wen), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data), .memwb_wen(memwb_wen),
        .memwb_rd(memwb_rd), .memwb_data(memwb_data), .stall(stall), .ex_valid(ex_valid),
        .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-set tables: what each opcode reads, writes and which ALU code it uses.
    int alu_of [16];
    bit reads_rs [16], reads_rt [16], uses_imm [16], writes [16], is_ld [16], is_st [16];

    initial begin
        for (int o = 0; o < 16; o++) begin
            alu_of[o] = 0; reads_rs[o] = 0; reads_rt[o] = 0;
            uses_imm[o] = 0; writes[o] = 0; is_ld[o] = 0; is_st[o] = 0;
        end
        for (int o = 0; o <= 5; o++) begin
            alu_of[o] = o; reads_rs[o] = 1; reads_rt[o] = 1; writes[o] = 1;
        end
        reads_rs[6] = 1; uses_imm[6] = 1; writes[6] = 1;
        reads_rs[7] = 1; uses_imm[7] = 1; writes[7] = 1; is_ld[7] = 1;
        reads_rs[8] = 1; reads_rt[8] = 1; uses_imm[8] = 1; is_st[8] = 1;
    end

    // Expected contents of ID/EX (m_*) and expected next contents (n_*).
    logic        m_valid, m_wen, m_mread, m_mwrite;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b, m_sd;
    logic [3:0]  m_rd;
    logic        n_valid, n_wen, n_mread, n_mwrite;
    logic [2:0]  n_op;
    logic [15:0] n_a, n_b, n_sd;
    logic [3:0]  n_rd;
    logic        e_stall, stall_seen;
    logic [3:0]  e_rs_addr, e_rt_addr;

    function automatic logic [15:0] value_of(input logic [3:0] r);
        if (r == 0) return 16'h0;
        if (m_valid && m_wen && m_rd == r && !m_mread) return ex_alu_result;
        if (exmem_wen && exmem_rd == r && !exmem_is_load) return exmem_data;
        if (memwb_wen && memwb_rd == r) return memwb_data;
        return rf[r];
    endfunction

    function automatic bit awaiting_load(input logic [3:0] r);
        return r != 0 && ((m_valid && m_mread && m_rd == r) ||
                          (exmem_wen && exmem_is_load && exmem_rd == r));
    endfunction

    task automatic model_eval();
        int          o;
        logic [3:0]  fd, fs, ft, src2;
        logic [15:0] immv;
        bit          haz;
        o    = int'(instr[15:12]);
        fd   = instr[11:8];
        fs   = instr[7:4];
        ft   = instr[3:0];
        src2 = is_st[o] ? fd : ft;
        immv = {{12{instr[3]}}, instr[3:0]};
        e_rs_addr = fs;
        e_rt_addr = src2;
        haz = (reads_rs[o] && awaiting_load(fs)) || (reads_rt[o] && awaiting_load(src2));
        e_stall = instr_valid && !flush && haz;
        {n_valid, n_wen, n_mread, n_mwrite} = 4'b0000;
        n_op = 3'd0; n_a = 16'h0; n_b = 16'h0; n_sd = 16'h0; n_rd = 4'h0;
        if (instr_valid && !flush && !e_stall) begin
            n_valid  = 1'b1;
            n_wen    = writes[o];
            n_mread  = is_ld[o];
            n_mwrite = is_st[o];
            n_op     = 3'(alu_of[o]);
            n_a      = reads_rs[o] ? value_of(fs) : 16'h0;
            n_b      = uses_imm[o] ? immv : (reads_rt[o] ? value_of(src2) : 16'h0);
            n_sd     = is_st[o] ? value_of(src2) : 16'h0;
            n_rd     = writes[o] ? fd : 4'h0;
        end
    endtask

    task automatic model_reset();
        {m_valid, m_wen, m_mread, m_mwrite} = 4'b0000;
        m_op = 3'd0; m_a = 16'h0; m_b = 16'h0; m_sd = 16'h0; m_rd = 4'h0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".ex_valid"},     32'(ex_valid),      32'(m_valid));
        check({tag, ".ex_reg_wen"},   32'(ex_reg_wen),    32'(m_wen));
        check({tag, ".ex_mem_read"},  32'(ex_mem_read),   32'(m_mread));
        check({tag, ".ex_mem_write"}, 32'(ex_mem_write),  32'(m_mwrite));
        check({tag, ".ex_alu_op"},    32'(ex_alu_op),     32'(m_op));
        check({tag, ".ex_a"},         32'(ex_a),          32'(m_a));
        check({tag, ".ex_b"},         32'(ex_b),          32'(m_b));
        check({tag, ".ex_store_data"},32'(ex_store_data), 32'(m_sd));
        check({tag, ".ex_rd"},        32'(ex_rd),         32'(m_rd));
    endtask

    // Called 1 ns after a rising edge with inputs already applied.
    task automatic step(input string tag);
        #2;
        model_eval();
        stall_seen = stall;
        check({tag, ".stall"},   32'(stall),   32'(e_stall));
        check({tag, ".rs_addr"}, 32'(rs_addr), 32'(e_rs_addr));
        check({tag, ".rt_addr"}, 32'(rt_addr), 32'(e_rt_addr));
        @(posedge clk);
        #1;
        {m_valid, m_wen, m_mread, m_mwrite} = {n_valid, n_wen, n_mread, n_mwrite};
        m_op = n_op; m_a = n_a; m_b = n_b; m_sd = n_sd; m_rd = n_rd;
        check_regs(tag);
    endtask

    task automatic quiet();
        instr_valid = 1'b1; flush = 1'b0;
        exmem_wen = 1'b0; exmem_is_load = 1'b0; exmem_rd = 4'h0; exmem_data = 16'h0;
        memwb_wen = 1'b0; memwb_rd = 4'h0; memwb_data = 16'h0;
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    initial begin
        rst = 1'b1;
        instr = 16'h0;
        ex_alu_result = 16'h0;
        quiet();
        instr_valid = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        model_reset();
        @(posedge clk);
        #1;
        check("reset.stall", 32'(stall), 32'h0);
        check_regs("reset");
        rst = 1'b0;

        // Plain R-type with no forwarding.
        quiet();
        rf[1] = 16'd5; rf[2] = 16'd7;
        instr = mk(4'd0, 4'd3, 4'd1, 4'd2);
        step("add");
        check("add.a", 32'(ex_a), 32'd5);
        check("add.b", 32'(ex_b), 32'd7);
        check("add.rd", 32'(ex_rd), 32'd3);
        check("add.wen", 32'(ex_reg_wen), 32'd1);

        // Back-to-back dependency from EX, then from EX/MEM.
        rf[3] = 16'd0; ex_alu_result = 16'd12;
        instr = mk(4'd1, 4'd4, 4'd3, 4'd1);
        step("b2b_ex");
        check("b2b_ex.a", 32'(ex_a), 32'd12);
        check("b2b_ex.nostall", 32'(stall_seen), 32'd0);
        exmem_wen = 1'b1; exmem_rd = 4'd3; exmem_data = 16'd12; ex_alu_result = 16'd99;
        step("b2b_mem");
        check("b2b_mem.a", 32'(ex_a), 32'd12);

        // Load-use: two stall cycles, then operands from MEM/WB.
        quiet();
        rf[1] = 16'd1; rf[5] = 16'h0;
        instr = mk(4'd7, 4'd5, 4'd1, 4'd2);
        step("lw");
        check("lw.mread", 32'(ex_mem_read), 32'd1);
        instr = mk(4'd0, 4'd6, 4'd5, 4'd5);
        step("lu1");
        check("lu1.stall", 32'(stall_seen), 32'd1);
        check("lu1.bubble", 32'(ex_valid), 32'd0);
        exmem_wen = 1'b1; exmem_is_load = 1'b1; exmem_rd = 4'd5; exmem_data = 16'h55;
        step("lu2");
        check("lu2.stall", 32'(stall_seen), 32'd1);
        check("lu2.bubble", 32'(ex_valid), 32'd0);
        exmem_wen = 1'b0; exmem_is_load = 1'b0;
        memwb_wen = 1'b1; memwb_rd = 4'd5; memwb_data = 16'h00AB;
        step("lu3");
        check("lu3.stall", 32'(stall_seen), 32'd0);
        check("lu3.a", 32'(ex_a), 32'h00AB);
        check("lu3.b", 32'(ex_b), 32'h00AB);

        // Store with negative immediate.
        quiet();
        rf[7] = 16'h1234; rf[2] = 16'd3;
        instr = mk(4'd8, 4'd7, 4'd2, 4'hF);
        step("sw");
        check("sw.b", 32'(ex_b), 32'hFFFF);
        check("sw.mwrite", 32'(ex_mem_write), 32'd1);
        check("sw.wen", 32'(ex_reg_wen), 32'd0);
        check("sw.sd", 32'(ex_store_data), 32'h1234);

        // Flush while a load-use stall is pending, then an illegal opcode.
        instr = mk(4'd7, 4'd5, 4'd1, 4'd2);
        step("fl_lw");
        instr = mk(4'd0, 4'd6, 4'd5, 4'd5);
        step("fl_stall");
        check("fl_stall.stall", 32'(stall_seen), 32'd1);
        exmem_wen = 1'b1; exmem_is_load = 1'b1; exmem_rd = 4'd5;
        flush = 1'b1;
        step("flush");
        check("flush.stall", 32'(stall_seen), 32'd0);
        check("flush.bubble", 32'(ex_valid), 32'd0);
        quiet();
        instr = mk(4'd12, 4'd3, 4'd1, 4'd2);
        step("nop");
        check("nop.valid", 32'(ex_valid), 32'd1);
        check("nop.enables", 32'({ex_reg_wen, ex_mem_read, ex_mem_write}), 32'd0);
        check("nop.op", 32'(ex_alu_op), 32'd0);
        check("nop.ab", 32'({ex_a, ex_b}), 32'd0);

        // Reset asserted while a load-use stall is active.
        instr = mk(4'd7, 4'd5, 4'd1, 4'd2);
        step("rs_lw");
        instr = mk(4'd0, 4'd6, 4'd5, 4'd5);
        #2;
        check("rs.pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("rs.stall", 32'(stall), 32'd0);
        check_regs("rs.async");
        @(posedge clk);
        #1;
        check_regs("rs.held");
        rst = 1'b0;
        rf[5] = 16'h0021;
        step("rs_after");
        check("rs_after.valid", 32'(ex_valid), 32'd1);
        check("rs_after.a", 32'(ex_a), 32'h0021);

        // Randomized traffic: small register range to provoke matches.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                             : 4'($urandom_range(0, 8));
            instr = mk(op, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                       4'($urandom));
            instr_valid   = ($urandom_range(0, 7) != 0);
            flush         = ($urandom_range(0, 11) == 0);
            ex_alu_result = 16'($urandom);
            exmem_wen     = 1'($urandom);
            exmem_is_load = 1'($urandom);
            exmem_rd      = 4'($urandom_range(0, 4));
            exmem_data    = 16'($urandom);
            memwb_wen     = 1'($urandom);
            memwb_rd      = 4'($urandom_range(0, 4));
            memwb_data    = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 15)] = 16'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Decode/issue stage of the 5-stage pipeline: the producer side of the ALU's `a`/`b`/`op` interface.
- Decodes the 16-bit instruction held in IF/ID and selects operands, with forwarding from EX, EX/MEM and MEM/WB.
- Detects load-use hazards; stalls IF/ID and inserts bubbles.
- Owns the ID/EX pipeline register that directly drives ALU `a`, `b` and `op`.

Parameters:
- DSIZE, 16, datapath width.
- RSIZE, 4, register address width (16 registers; r0 reads as zero).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  IF/ID holds a real instruction.
- instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt or imm4.
- flush  in  1  kill the instruction in ID (taken branch).
- rs_addr, rt_addr  out  RSIZE  register-file read addresses (combinational from instr).
- rs_data, rt_data  in  DSIZE  register-file read data (combinational).
- ex_alu_result  in  DSIZE  live ALU output for the instruction in ID/EX.
- exmem_wen, exmem_is_load  in  1  EX/MEM writes a register; EX/MEM is a load.
- exmem_rd  in  RSIZE; exmem_data  in  DSIZE.
- memwb_wen  in  1; memwb_rd  in  RSIZE; memwb_data  in  DSIZE.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write  out  1  registered.
- ex_alu_op  out  3; ex_a, ex_b, ex_store_data  out  DSIZE; ex_rd  out  RSIZE  registered.

Behaviour:
- Opcode decode:
  - 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 COM, 5 MUL: R-type, a=rs, b=rt, write rd.
  - 6 ADDI: a=rs, b=sext(imm4), write rd.
  - 7 LW: a=rs, b=sext(imm4), mem_read, write rd.
  - 8 SW: a=rs, b=sext(imm4), mem_write, store_data = reg[rd], no write.
  - 9-15: illegal, issued as a valid NOP (all enables 0, alu_op ADD, operands 0).
- alu_op codes: ADD/ADDI/LW/SW=000, SUB=001, AND=010, XOR=011, COM=100, MUL=101.
- Sources:
  - R-type reads rs and rt; SW reads rs and rd (as rt_addr); ADDI/LW read rs only.
  - rt_addr = rd field for SW, else the rt field.
- Operand resolution per source register r, first match wins:
  - r==0 -> 0.
  - ID/EX valid, reg_wen, ex_rd==r, not a load -> ex_alu_result.
  - exmem_wen, exmem_rd==r, not a load -> exmem_data.
  - memwb_wen, memwb_rd==r -> memwb_data.
  - else register-file data.
- Hazard: stall=1 when instr_valid, flush=0, and any used nonzero source matches either:
  - (ID/EX valid & mem_read & ex_rd), or
  - (exmem_wen & exmem_is_load & exmem_rd).
- Result: a load-use costs exactly 2 bubbles.
- FSM states: RUN, STALL.
  - RUN -> STALL when stall is asserted.
  - STALL -> RUN when the hazard clears.
  - STALL -> STALL while the hazard persists.
  - flush forces RUN.
  - The state is informational only and exported to no port; stall itself is combinational.
- ID/EX update each clock:
  - flush, !instr_valid or stall: load a bubble (ex_valid=0, reg_wen/mem_read/mem_write=0, data fields 0).
  - Otherwise: load the decoded instruction with ex_valid=1.
  - flush overrides stall; stall=0 whenever flush=1.
- Arithmetic: sext(imm4) replicates bit 3 into bits DSIZE-1:4; no other arithmetic is done here.
- Reset (asynchronous, active-high):
  - All ex_* outputs go to 0 immediately and the FSM goes to RUN.
  - stall reads 0 while rst=1.
  - Mid-stall reset discards the held instruction's issue; IF restarts.
- Simultaneous writers to the same r: EX beats EX/MEM beats MEM/WB (youngest wins).

Test Plan:
- Reset during stall: assert rst mid-STALL -> ex_valid=0 and all ex_* outputs 0 same cycle; stall=0; after release, the first instruction issues normally.
- ADD r3,r1,r2 with rs_data=5, rt_data=7, no forwarding -> next cycle ex_valid=1, ex_alu_op=000, ex_a=5, ex_b=7, ex_rd=3, ex_reg_wen=1.
- Back-to-back dependency:
  - Stimulus: SUB r4,r3,r1 immediately after ADD r3, with ex_alu_result=12 and rs_data(r3)=0 (stale).
  - Required: ex_a=12, no stall.
  - Repeat with the producer in EX/MEM (exmem_data=12) -> ex_a=12.
- Load-use:
  - Stimulus: LW r5,2(r1) followed by ADD r6,r5,r5.
  - Required: stall=1 for 2 cycles, two bubbles issued; ADD issues on cycle 3 with ex_a=ex_b=memwb_data.
- SW r7,-1(r2) with imm4=4'hF -> ex_b=16'hFFFF, ex_mem_write=1, ex_reg_wen=0, ex_store_data=reg[7].
- flush during load-use stall -> stall=0 that cycle, a bubble is issued, FSM goes to RUN; opcode 12 issues as a NOP with ex_valid=1 and all enables 0.
